// File: rtl/spi_clk_pll_seq_if.sv
// Control/status bundle between the SPI PLL sequencer and its environment.
// Optional loss counter signals exist only with SPI_CLK_PLL_SEQ_LOSS_CNT_EN.
interface spi_clk_pll_seq_if;
  logic       en;
  logic       sleep_req;
  logic       pll_extlock;
  logic       pll_reset;
  logic       pll_stdby;
  logic       clk_rdy;
  logic       lock_lost;
  logic       fail;
  logic [2:0] state_o;
`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
  logic       loss_clr;
  logic [7:0] loss_cnt;

  modport master (output en, sleep_req, pll_extlock, loss_clr,
                  input  pll_reset, pll_stdby, clk_rdy, lock_lost, fail, state_o, loss_cnt);
  modport slave  (input  en, sleep_req, pll_extlock, loss_clr,
                  output pll_reset, pll_stdby, clk_rdy, lock_lost, fail, state_o, loss_cnt);
`else
  modport master (output en, sleep_req, pll_extlock,
                  input  pll_reset, pll_stdby, clk_rdy, lock_lost, fail, state_o);
  modport slave  (input  en, sleep_req, pll_extlock,
                  output pll_reset, pll_stdby, clk_rdy, lock_lost, fail, state_o);
`endif
endinterface

// File: rtl/spi_clk_pll_seq.sv
// SPI clock PLL sequencer on refclk: reset/standby control, lock qualification, retries.
// Define SPI_CLK_PLL_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module spi_clk_pll_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 12
) (
  input  logic               refclk,
  input  logic               reset,
  spi_clk_pll_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_STDBY  = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] L_RST_TC = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO_TC  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_STB_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] L_MAX_RTY = RTY_W'(MAX_RETRY);

  logic             r_sync1, r_sync2;
  logic             w_lock_s;
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_tc;
  logic [RTY_W-1:0] r_retry, w_retry_next;
  logic             w_lost_next;
  logic             r_pll_reset, r_pll_stdby, r_clk_rdy, r_lock_lost, r_fail;
  logic             w_pll_reset_next, w_pll_stdby_next, w_clk_rdy_next, w_fail_next;

  // extlock comes from the PLL analog domain; double-flop before use
  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pll_extlock;
      r_sync2 <= r_sync1;
    end
  end
  assign w_lock_s = r_sync2;

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_pll_stdby <= 1'b1;
      r_clk_rdy   <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_retry     <= w_retry_next;
      r_pll_reset <= w_pll_reset_next;
      r_pll_stdby <= w_pll_stdby_next;
      r_clk_rdy   <= w_clk_rdy_next;
      r_lock_lost <= w_lost_next;
      r_fail      <= w_fail_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_lost_next  = 1'b0;
    w_cnt_tc     = '0;
    case (r_state)
      S_OFF: begin
        w_state_next = S_RESET;
        w_retry_next = '0;
      end
      S_RESET: begin
        w_cnt_tc = L_RST_TC;
        if (r_cnt == L_RST_TC) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_tc = L_TO_TC;
        // a lock seen on the timeout cycle still wins
        if (w_lock_s) begin
          w_state_next = S_SETTLE;
        end else if (r_cnt == L_TO_TC) begin
          if (r_retry < L_MAX_RTY) begin
            w_retry_next = r_retry + 1'b1;
            w_state_next = S_RESET;
          end else begin
            w_state_next = S_FAIL;
          end
        end
      end
      S_SETTLE: begin
        w_cnt_tc = L_STB_TC;
        if (!w_lock_s) begin
          w_state_next = S_WAIT;
        end else if (r_cnt == L_STB_TC) begin
          w_state_next = S_RUN;
          w_retry_next = '0;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_next = S_RESET;
          w_lost_next  = 1'b1;
          w_retry_next = '0;
        end else if (bus.sleep_req) begin
          w_state_next = S_STDBY;
        end
      end
      S_STDBY: begin
        if (!bus.sleep_req) w_state_next = S_RESET;
      end
      S_FAIL:  w_state_next = S_FAIL;
      default: w_state_next = S_OFF;
    endcase

    if (!bus.en) begin
      w_state_next = S_OFF;
      w_retry_next = '0;
      w_lost_next  = 1'b0;
    end

    if (w_state_next != r_state)  w_cnt_next = '0;
    else if (r_cnt < w_cnt_tc)    w_cnt_next = r_cnt + 1'b1;
    else                          w_cnt_next = r_cnt;
  end

  // Outputs decode the next state so the registered outputs line up with r_state
  always_comb begin
    w_pll_reset_next = 1'b0;
    w_pll_stdby_next = 1'b0;
    w_clk_rdy_next   = 1'b0;
    w_fail_next      = 1'b0;
    case (w_state_next)
      S_OFF:   begin w_pll_reset_next = 1'b1; w_pll_stdby_next = 1'b1; end
      S_RESET: w_pll_reset_next = 1'b1;
      S_RUN:   w_clk_rdy_next   = 1'b1;
      S_STDBY: w_pll_stdby_next = 1'b1;
      S_FAIL:  begin w_pll_reset_next = 1'b1; w_pll_stdby_next = 1'b1; w_fail_next = 1'b1; end
      default: ;
    endcase
  end

  assign bus.pll_reset = r_pll_reset;
  assign bus.pll_stdby = r_pll_stdby;
  assign bus.clk_rdy   = r_clk_rdy;
  assign bus.lock_lost = r_lock_lost;
  assign bus.fail      = r_fail;
  assign bus.state_o   = r_state;

`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  // counts visible lock_lost pulses; clear takes precedence
  always_ff @(posedge refclk or negedge reset) begin
    if (!reset)                                   r_loss_cnt <= 8'd0;
    else if (bus.loss_clr)                        r_loss_cnt <= 8'd0;
    else if (r_lock_lost && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
  end
  assign bus.loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_spi_clk_pll_seq.sv
// Bench for spi_clk_pll_seq: directed bring-up/fault scenarios plus random stimulus,
// all cycles checked against a dwell-time model of the sequencer.
module tb_spi_clk_pll_seq;
  localparam int RSTC = 4;
  localparam int TO   = 32;
  localparam int STB  = 8;
  localparam int MR   = 2;

  logic refclk;
  logic reset;
  spi_clk_pll_seq_if bus();

  spi_clk_pll_seq #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB), .MAX_RETRY(MR), .CNT_W(12)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #20 refclk = ~refclk;

  typedef struct packed {
    int   st;
    int   dw;
    int   rt;
    logic pulse;
  } mstate_t;

  mstate_t m;
  logic    m_x1, m_x2;
  int      m_loss;

  function automatic mstate_t step(mstate_t c, logic lk, logic e, logic sl);
    mstate_t n;
    n = c;
    n.pulse = 1'b0;
    if (!e) begin
      n.st = 0;
    end else begin
      case (c.st)
        0: begin n.st = 1; n.rt = 0; end
        1: if (c.dw + 1 >= RSTC) n.st = 2;
        2: if (lk) n.st = 3;
           else if (c.dw + 1 >= TO) begin
             if (c.rt < MR) begin n.rt = c.rt + 1; n.st = 1; end
             else n.st = 6;
           end
        3: if (!lk) n.st = 2;
           else if (c.dw + 1 >= STB) begin n.st = 4; n.rt = 0; end
        4: if (!lk) begin n.st = 1; n.pulse = 1'b1; n.rt = 0; end
           else if (sl) n.st = 5;
        5: if (!sl) n.st = 1;
        default: ;
      endcase
    end
    n.dw = (n.st != c.st) ? 0 : c.dw + 1;
    return n;
  endfunction

  always @(posedge refclk or negedge reset) begin
    if (!reset) begin
      m      <= '{st: 0, dw: 0, rt: 0, pulse: 1'b0};
      m_x1   <= 1'b0;
      m_x2   <= 1'b0;
      m_loss <= 0;
    end else begin
      m_x1 <= bus.pll_extlock;
      m_x2 <= m_x1;
      m    <= step(m, m_x2, bus.en, bus.sleep_req);
`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
      if (bus.loss_clr)                m_loss <= 0;
      else if (m.pulse && m_loss < 255) m_loss <= m_loss + 1;
`endif
    end
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  int   c_rst_cyc = 0, c_wait_cyc = 0, c_pulse = 0, c_rst_entries = 0;
  int   slog[$];
  logic [3:0] last_st = 4'hF;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("model_state", int'(bus.state_o), m.st);
    chk("model_pll_reset", int'(bus.pll_reset), int'(m.st == 0 || m.st == 1 || m.st == 6));
    chk("model_pll_stdby", int'(bus.pll_stdby), int'(m.st == 0 || m.st == 5 || m.st == 6));
    chk("model_clk_rdy", int'(bus.clk_rdy), int'(m.st == 4));
    chk("model_fail", int'(bus.fail), int'(m.st == 6));
    chk("model_lock_lost", int'(bus.lock_lost), int'(m.pulse));
`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
    chk("model_loss_cnt", int'(bus.loss_cnt), m_loss);
`endif
  endtask

  task automatic tick();
    @(negedge refclk);
    #2;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(bus.state_o) != s && n < budget) begin tick(); n++; end
    chk(nm, int'(bus.state_o), s);
  endtask

  task automatic wait_rdy(input int budget, input string nm);
    int n = 0;
    while (!bus.clk_rdy && n < budget) begin tick(); n++; end
    chk(nm, int'(bus.clk_rdy), 1);
  endtask

  task automatic run_tests();
    int n, b_r, b_w, b_p, b_e, b_log;

    // reset state
    bus.en = 1'b0; bus.sleep_req = 1'b0; bus.pll_extlock = 1'b0;
`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
    bus.loss_clr = 1'b0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_pll_reset", int'(bus.pll_reset), 1);
    chk("rst_pll_stdby", int'(bus.pll_stdby), 1);
    chk("rst_clk_rdy", int'(bus.clk_rdy), 0);
    chk("rst_lock_lost", int'(bus.lock_lost), 0);
    chk("rst_fail", int'(bus.fail), 0);
    reset = 1'b1;
    tick();
    chk("off_idle", int'(bus.state_o), 0);
    $display("txn reset: outputs at reset values");

    // normal bring-up
    b_r = c_rst_cyc; b_log = slog.size();
    bus.en = 1'b1;
    wait_state(2, 50, "s1_reach_wait");
    chk("s1_reset_len", c_rst_cyc - b_r, 4);
    repeat (10) tick();
    bus.pll_extlock = 1'b1;
    n = 0;
    while (!bus.clk_rdy && n < 100) begin tick(); n++; end
    chk("s1_rdy_latency", n, 11);
    chk("s1_seq_len", slog.size() - b_log, 4);
    for (int i = 0; i < 4; i++)
      chk("s1_seq", (b_log + i < slog.size()) ? slog[b_log + i] : -1, i + 1);
    $display("txn bringup: clk_rdy after %0d cycles", n);

    // lock glitch during SETTLE
    bus.en = 1'b0; tick(); bus.en = 1'b1;
    wait_state(3, 100, "s2_reach_settle");
    repeat (3) tick();
    bus.pll_extlock = 1'b0; tick(); bus.pll_extlock = 1'b1;
    chk("s2_still_settle", int'(bus.state_o), 3);
    b_log = slog.size();
    n = 0;
    while (!bus.clk_rdy && n < 100) begin tick(); n++; end
    chk("s2_rdy_latency", n, 11);
    chk("s2_seq_len", slog.size() - b_log, 3);
    for (int i = 0; i < 3; i++)
      chk("s2_seq", (b_log + i < slog.size()) ? slog[b_log + i] : -1, i + 2);
    $display("txn glitch: relock after %0d cycles", n);

    // timeout, retries, fail
    bus.pll_extlock = 1'b0; bus.en = 1'b0; tick(); bus.en = 1'b1;
    b_e = c_rst_entries; b_w = c_wait_cyc; b_r = c_rst_cyc;
    n = 0;
    while (!bus.fail && n < 400) begin tick(); n++; end
    chk("s3_fail", int'(bus.fail), 1);
    chk("s3_reset_pulses", c_rst_entries - b_e, 3);
    chk("s3_reset_cycles", c_rst_cyc - b_r, 12);
    chk("s3_wait_cycles", c_wait_cyc - b_w, 96);
    chk("s3_pll_reset", int'(bus.pll_reset), 1);
    chk("s3_pll_stdby", int'(bus.pll_stdby), 1);
    chk("s3_state", int'(bus.state_o), 6);
    repeat (5) tick();
    chk("s3_fail_sticky", int'(bus.fail), 1);
    bus.en = 1'b0; tick();
    chk("s3_off_state", int'(bus.state_o), 0);
    chk("s3_off_fail", int'(bus.fail), 0);
    $display("txn timeout: fail after %0d cycles", n);

    // lock loss in RUN
    bus.pll_extlock = 1'b1; bus.en = 1'b1;
    wait_rdy(200, "s4_bringup");
    b_p = c_pulse;
    bus.pll_extlock = 1'b0;
    n = 0;
    while (bus.clk_rdy && n < 10) begin tick(); n++; end
    chk("s4_rdy_fall_edges", n, 3);
    chk("s4_lock_lost_hi", int'(bus.lock_lost), 1);
    chk("s4_state_reset", int'(bus.state_o), 1);
    tick();
    chk("s4_lock_lost_lo", int'(bus.lock_lost), 0);
    bus.pll_extlock = 1'b1;
    wait_rdy(200, "s4_relock");
    chk("s4_pulse_count", c_pulse - b_p, 1);
`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
    chk("s4_loss_cnt", int'(bus.loss_cnt), 1);
`endif
    $display("txn lockloss: clk_rdy fell after %0d edges", n);

    // standby
    b_p = c_pulse;
    bus.sleep_req = 1'b1;
    repeat (5) tick();
    bus.pll_extlock = 1'b0;
    repeat (45) tick();
    chk("s5_state", int'(bus.state_o), 5);
    chk("s5_pll_stdby", int'(bus.pll_stdby), 1);
    chk("s5_pll_reset", int'(bus.pll_reset), 0);
    chk("s5_clk_rdy", int'(bus.clk_rdy), 0);
    chk("s5_no_pulse", c_pulse - b_p, 0);
    b_r = c_rst_cyc;
    bus.sleep_req = 1'b0;
    repeat (6) tick();
    bus.pll_extlock = 1'b1;
    wait_rdy(200, "s5_relock");
    chk("s5_reset_cycles", c_rst_cyc - b_r, 4);
    $display("txn standby: relocked");

    // asynchronous reset while in WAIT_LOCK
    bus.pll_extlock = 1'b0; bus.en = 1'b0; tick(); bus.en = 1'b1;
    wait_state(2, 50, "s6_reach_wait");
    repeat (5) tick();
    @(posedge refclk);
    #5 reset = 1'b0;
    #1;
    chk("s6_state", int'(bus.state_o), 0);
    chk("s6_pll_reset", int'(bus.pll_reset), 1);
    chk("s6_pll_stdby", int'(bus.pll_stdby), 1);
    chk("s6_clk_rdy", int'(bus.clk_rdy), 0);
    chk("s6_fail", int'(bus.fail), 0);
    #4 reset = 1'b1;
    tick();
    chk("s6_state_after", int'(bus.state_o), 0);
    wait_state(1, 10, "s6_restart");
    $display("txn async_reset: immediate return to OFF");

`ifdef SPI_CLK_PLL_SEQ_LOSS_CNT_EN
    bus.pll_extlock = 1'b1;
    wait_rdy(200, "s7_bringup");
    for (int i = 0; i < 258; i++) begin
      bus.pll_extlock = 1'b0;
      wait_state(1, 10, "s7_loss");
      bus.pll_extlock = 1'b1;
      wait_rdy(100, "s7_relock");
    end
    tick();
    chk("s7_loss_sat", int'(bus.loss_cnt), 255);
    bus.loss_clr = 1'b1; tick(); bus.loss_clr = 1'b0; tick();
    chk("s7_loss_clr", int'(bus.loss_cnt), 0);
    $display("txn loss_cnt: saturated and cleared");
`endif

    // randomized segments, checked cycle by cycle by the model
    for (int s = 0; s < 80; s++) begin
      int d;
      d = $urandom_range(1, 70);
      bus.pll_extlock = ($urandom_range(0, 9) < 7);
      bus.sleep_req   = ($urandom_range(0, 9) < 2);
      bus.en          = ($urandom_range(0, 29) != 0);
      repeat (d) tick();
    end
    $display("txn random: 80 segments done");
  endtask

  initial begin
    reset = 1'b1;
    fork
      begin
        forever begin
          @(negedge refclk);
          cmp_all();
          if (reset) begin
            if (bus.pll_reset && !bus.pll_stdby) c_rst_cyc++;
            if (bus.state_o == 3'd2) c_wait_cyc++;
            if (bus.lock_lost) c_pulse++;
          end
          if ({1'b0, bus.state_o} != last_st) begin
            slog.push_back(int'(bus.state_o));
            if (bus.state_o == 3'd1) c_rst_entries++;
            last_st = {1'b0, bus.state_o};
          end
        end
      end
      begin
        run_tests();
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_clk_pll_seq.md
Name: spi_clk_pll_seq

Overview:
- Sequencer for the SPI clock PLL wrapper: drives its reset and stdby inputs, monitors extlock, and issues a qualified clk_rdy.
- Runs on the PLL reference clock (refclk), never on the PLL output.
- Handles power-up, lock timeout with bounded retries, lock loss, standby entry/exit and hard failure.
- Downstream SPI logic treats clk_rdy as the only permission to use clk0_out.

Parameters:
RST_CYCLES, 16, cycles pll_reset held high in RESET (>=2)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before a retry
STABLE_CYCLES, 256, consecutive synchronized-lock cycles required in SETTLE
MAX_RETRY, 3, retries after the first attempt before FAIL
CNT_W, 12, shared cycle counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
refclk  in  1  reference clock, 25 MHz, sole clock
reset  in  1  asynchronous, active-low block reset
en  in  1  level: 1 = PLL wanted running
sleep_req  in  1  level: 1 = place PLL in standby (honoured only from RUN)
pll_extlock  in  1  PLL extlock, asynchronous to refclk
pll_reset  out  1  to PLL reset, active-high
pll_stdby  out  1  to PLL stdby, active-high
clk_rdy  out  1  PLL output locked and stable
lock_lost  out  1  one-cycle pulse on lock loss in RUN
fail  out  1  retries exhausted, sticky until en=0
state_o  out  3  current state code, for debug

Behaviour:
- States and codes: OFF=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, STDBY=5, FAIL=6. All outputs are registered Moore decodes; lock_lost is a registered pulse.
- Lock synchronizer: 2-flop synchronizer on pll_extlock produces lock_s. Both flops reset to 0.
- Reset (reset=0): state=OFF, pll_reset=1, pll_stdby=1, clk_rdy=0, lock_lost=0, fail=0, counter=0, retry=0. Asserting reset mid-operation aborts immediately to these values.
- Global rule: en=0 in any state goes to OFF on the next edge. This has the highest priority.
- OFF: pll_reset=1, pll_stdby=1. en=1 goes to RESET; counter and retry cleared.
- RESET: pll_reset=1, pll_stdby=0. After exactly RST_CYCLES cycles in RESET, go to WAIT_LOCK; counter cleared.
- WAIT_LOCK: pll_reset=0, pll_stdby=0.
  - lock_s=1: go to SETTLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: if retry<MAX_RETRY, retry++ and go to RESET; otherwise go to FAIL.
  - If lock_s=1 on the timeout cycle, lock wins.
- SETTLE: outputs as WAIT_LOCK.
  - lock_s=0: go back to WAIT_LOCK with the counter cleared (full new timeout).
  - STABLE_CYCLES consecutive lock_s=1 cycles: go to RUN; retry cleared.
- RUN: clk_rdy=1. Priority en=0 > lock loss > sleep.
  - lock_s=0: go to RESET, lock_lost=1 for one cycle, retry=0.
  - sleep_req=1: go to STDBY.
  - clk_rdy falls within 3 refclk edges of pll_extlock falling (2 sync + 1 state).
- STDBY: pll_stdby=1, pll_reset=0, clk_rdy=0. lock_s is ignored. sleep_req=0 goes to RESET; a full relock is always required.
- FAIL: pll_reset=1, pll_stdby=1, fail=1. Exits only via en=0 to OFF.
- Counter arithmetic: unsigned, cleared on every state change, never wraps. It increments only while below the active terminal count.
- sleep_req outside RUN has no effect; it is re-evaluated once RUN is reached.

Optional Feature:
- Macro: SPI_CLK_PLL_SEQ_LOSS_CNT_EN.
- Defined:
  - Adds output loss_cnt [7:0], a saturating count of lock_lost pulses (stops at 255).
  - Adds input loss_clr (1 bit), which synchronously zeros it.
  - loss_clr and lock_lost in the same cycle: result is 0.
  - Count resets to 0 on reset; en=0 does not clear it.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2.
- Normal bring-up: reset released, en=1, extlock rises 10 cycles after leaving RESET.
  -> pll_reset high exactly 4 cycles with pll_stdby=0.
  -> clk_rdy=1 exactly 2+1+8 cycles after extlock rise.
  -> state_o sequence 0,1,2,3,4.
- Lock glitch in SETTLE: extlock low for 1 cycle after 5 stable cycles.
  -> returns to WAIT_LOCK, counter restarts, clk_rdy stays 0.
  -> RUN reached only after 8 further consecutive locked cycles.
- Timeout and fail: extlock held 0.
  -> 3 RESET pulses of 4 cycles, each followed by 32 WAIT_LOCK cycles.
  -> then fail=1, pll_reset=1, pll_stdby=1.
  -> en=0 returns to OFF and fail=0.
- Lock loss in RUN: drop extlock.
  -> clk_rdy=0 within 3 edges and lock_lost high exactly 1 cycle.
  -> state goes RESET, then relocks.
  -> with macro defined, loss_cnt=1; after 256 losses loss_cnt=255.
- Standby: in RUN assert sleep_req for 50 cycles while extlock drops.
  -> pll_stdby=1, no lock_lost pulse.
  -> on release: RESET (4 cycles), full relock, clk_rdy=1.
- Async reset mid-WAIT_LOCK: reset=0 for a fraction of a cycle.
  -> all outputs return to their reset values immediately, without waiting for a refclk edge.
  -> state_o=0.
